// File: rtl/dcache_wshr_issue_ctrl_pkg.sv
// Shared dcache definitions for the WSHR issue controller: geometry
// derived from the dcache defines and the controller state encoding.

`ifndef DCACHE_SETIDXBITS
`define DCACHE_SETIDXBITS 6
`endif
`ifndef DCACHE_TAGBITS
`define DCACHE_TAGBITS 20
`endif
`ifndef DCACHE_WSHR_ENTRY
`define DCACHE_WSHR_ENTRY 4
`endif

package dcache_wshr_issue_ctrl_pkg;

  localparam int unsigned DCACHE_BADDR_W    = `DCACHE_SETIDXBITS + `DCACHE_TAGBITS;
  localparam int unsigned DCACHE_WSHR_DEPTH = `DCACHE_WSHR_ENTRY;
  localparam int unsigned DCACHE_WSHR_IDX_W =
    (DCACHE_WSHR_DEPTH > 1) ? $clog2(DCACHE_WSHR_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wshr_state_e;

endpackage

// File: rtl/dcache_wshr_issue_ctrl.sv
// Dcache write-miss issue controller: allocates writes into the external
// WSHR, issues one memory write per allocation, pops entries on acknowledge
// and drains all outstanding writes for a fence.

module dcache_wshr_issue_ctrl
  import dcache_wshr_issue_ctrl_pkg::*;
#(
  parameter int unsigned BADDR_W = DCACHE_BADDR_W,
  parameter int unsigned DEPTH   = DCACHE_WSHR_DEPTH,
  parameter int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [BADDR_W-1:0] wr_blockaddr_i,
  input  logic               fence_valid_i,
  output logic               fence_ready_o,
  output logic               fence_done_o,
  output logic               wshr_push_valid_o,
  input  logic               wshr_push_ready_i,
  output logic [BADDR_W-1:0] wshr_push_blockaddr_o,
  input  logic               wshr_conflict_i,
  input  logic [IDX_W-1:0]   wshr_pushed_idx_i,
  input  logic               wshr_empty_i,
  output logic               wshr_pop_valid_o,
  output logic [IDX_W-1:0]   wshr_pop_idx_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [BADDR_W-1:0] mem_req_blockaddr_o,
  output logic [IDX_W-1:0]   mem_req_source_o,
  input  logic               mem_rsp_valid_i,
  input  logic [IDX_W-1:0]   mem_rsp_source_i,
  output logic               busy_o,
  output logic               err_o
);

  wshr_state_e        state_q;
  logic [DEPTH-1:0]   outst_q;
  logic [DEPTH-1:0]   outst_d;
  logic [BADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]   idx_q;
  logic               err_q;

  logic               accept;
  logic               rsp_hit;
  logic [DEPTH-1:0]   rsp_onehot;
  logic [DEPTH-1:0]   push_onehot;

  // Handshake decode; strobes to the WSHR are masked while reset is held
  always_comb begin
    rsp_onehot  = DEPTH'(1) << mem_rsp_source_i;
    push_onehot = DEPTH'(1) << wshr_pushed_idx_i;
    rsp_hit     = mem_rsp_valid_i & (|(outst_q & rsp_onehot));
    accept      = !rst && (state_q == IDLE) && !fence_valid_i && wr_valid_i
                  && wshr_push_ready_i && !wshr_conflict_i;
  end

  // Outstanding mask: clear on acknowledge first, so a same-index push wins
  always_comb begin
    outst_d = outst_q;
    if (rsp_hit) begin
      outst_d = outst_d & ~rsp_onehot;
    end
    if (accept) begin
      outst_d = outst_d | push_onehot;
    end
  end

  // Controller FSM with latched request fields and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      outst_q <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      if (mem_rsp_valid_i && !rsp_hit) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (fence_valid_i) begin
            state_q <= DRAIN;
          end else if (accept) begin
            addr_q  <= wr_blockaddr_i;
            idx_q   <= wshr_pushed_idx_i;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready_i) begin
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if ((outst_q == '0) && wshr_empty_i) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output drive: status from registered state, strobes from the decode above
  always_comb begin
    wr_ready_o            = accept;
    wshr_push_valid_o     = accept;
    wshr_push_blockaddr_o = wr_blockaddr_i;
    fence_ready_o         = !rst && (state_q == IDLE);
    fence_done_o          = (state_q == DONE);
    wshr_pop_valid_o      = !rst && rsp_hit;
    wshr_pop_idx_o        = (!rst && rsp_hit) ? mem_rsp_source_i : '0;
    mem_req_valid_o       = (state_q == ISSUE);
    mem_req_blockaddr_o   = addr_q;
    mem_req_source_o      = idx_q;
    busy_o                = (state_q != IDLE) || (outst_q != '0);
    err_o                 = err_q;
  end

endmodule

// File: tb/tb_dcache_wshr_issue_ctrl.sv
// Directed bench for dcache_wshr_issue_ctrl (DEPTH=4, 12-bit block address).

module tb_dcache_wshr_issue_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned IW = 2;

  logic          clk;
  logic          rst;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [AW-1:0] wr_blockaddr_i;
  logic          fence_valid_i;
  logic          fence_ready_o;
  logic          fence_done_o;
  logic          wshr_push_valid_o;
  logic          wshr_push_ready_i;
  logic [AW-1:0] wshr_push_blockaddr_o;
  logic          wshr_conflict_i;
  logic [IW-1:0] wshr_pushed_idx_i;
  logic          wshr_empty_i;
  logic          wshr_pop_valid_o;
  logic [IW-1:0] wshr_pop_idx_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [AW-1:0] mem_req_blockaddr_o;
  logic [IW-1:0] mem_req_source_o;
  logic          mem_rsp_valid_i;
  logic [IW-1:0] mem_rsp_source_i;
  logic          busy_o;
  logic          err_o;

  dcache_wshr_issue_ctrl #(
    .BADDR_W (AW),
    .DEPTH   (4),
    .IDX_W   (IW)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .wr_valid_i            (wr_valid_i),
    .wr_ready_o            (wr_ready_o),
    .wr_blockaddr_i        (wr_blockaddr_i),
    .fence_valid_i         (fence_valid_i),
    .fence_ready_o         (fence_ready_o),
    .fence_done_o          (fence_done_o),
    .wshr_push_valid_o     (wshr_push_valid_o),
    .wshr_push_ready_i     (wshr_push_ready_i),
    .wshr_push_blockaddr_o (wshr_push_blockaddr_o),
    .wshr_conflict_i       (wshr_conflict_i),
    .wshr_pushed_idx_i     (wshr_pushed_idx_i),
    .wshr_empty_i          (wshr_empty_i),
    .wshr_pop_valid_o      (wshr_pop_valid_o),
    .wshr_pop_idx_o        (wshr_pop_idx_o),
    .mem_req_valid_o       (mem_req_valid_o),
    .mem_req_ready_i       (mem_req_ready_i),
    .mem_req_blockaddr_o   (mem_req_blockaddr_o),
    .mem_req_source_o      (mem_req_source_o),
    .mem_rsp_valid_i       (mem_rsp_valid_i),
    .mem_rsp_source_i      (mem_rsp_source_i),
    .busy_o                (busy_o),
    .err_o                 (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst, wv;
    logic [AW-1:0] addr;
    logic          fv, pr, cf;
    logic [IW-1:0] pidx;
    logic          emp, mr, rv;
    logic [IW-1:0] rs;
    logic          e_wr, e_fr, e_fd, e_pop;
    logic [IW-1:0] e_pidx;
    logic          e_mv;
    logic [AW-1:0] e_ma;
    logic [IW-1:0] e_ms;
    logic          e_busy, e_err;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cur = 0;
  vec_t        vecs[$];

  function automatic vec_t V(
    input logic r, wv, input logic [AW-1:0] a, input logic fv, pr, cf,
    input logic [IW-1:0] pi, input logic emp, mr, rv, input logic [IW-1:0] rs,
    input logic ewr, efr, efd, epop, input logic [IW-1:0] epi, input logic emv,
    input logic [AW-1:0] ema, input logic [IW-1:0] ems, input logic eb, ee);
    vec_t v;
    v.rst = r; v.wv = wv; v.addr = a; v.fv = fv; v.pr = pr; v.cf = cf;
    v.pidx = pi; v.emp = emp; v.mr = mr; v.rv = rv; v.rs = rs;
    v.e_wr = ewr; v.e_fr = efr; v.e_fd = efd; v.e_pop = epop; v.e_pidx = epi;
    v.e_mv = emv; v.e_ma = ema; v.e_ms = ems; v.e_busy = eb; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, cur, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; wr_valid_i = v.wv; wr_blockaddr_i = v.addr; fence_valid_i = v.fv;
    wshr_push_ready_i = v.pr; wshr_conflict_i = v.cf; wshr_pushed_idx_i = v.pidx;
    wshr_empty_i = v.emp; mem_req_ready_i = v.mr; mem_rsp_valid_i = v.rv;
    mem_rsp_source_i = v.rs;
  endtask

  task automatic compare(input vec_t v);
    chk("wr_ready", 32'(wr_ready_o), 32'(v.e_wr));
    chk("push_valid", 32'(wshr_push_valid_o), 32'(v.e_wr));
    chk("fence_ready", 32'(fence_ready_o), 32'(v.e_fr));
    chk("fence_done", 32'(fence_done_o), 32'(v.e_fd));
    chk("pop_valid", 32'(wshr_pop_valid_o), 32'(v.e_pop));
    chk("pop_idx", 32'(wshr_pop_idx_o), 32'(v.e_pidx));
    chk("mem_valid", 32'(mem_req_valid_o), 32'(v.e_mv));
    chk("mem_addr", 32'(mem_req_blockaddr_o), 32'(v.e_ma));
    chk("mem_src", 32'(mem_req_source_o), 32'(v.e_ms));
    chk("busy", 32'(busy_o), 32'(v.e_busy));
    chk("err", 32'(err_o), 32'(v.e_err));
    if (v.e_wr) chk("push_addr", 32'(wshr_push_blockaddr_o), 32'(v.addr));
  endtask

  // Inputs applied just after the falling edge, outputs sampled 1 time unit later
  task automatic step(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    compare(v);
    cur++;
  endtask

  vec_t idle_v;

  initial begin
    rst = 1'b1; wr_valid_i = 1'b0; wr_blockaddr_i = '0; fence_valid_i = 1'b0;
    wshr_push_ready_i = 1'b0; wshr_conflict_i = 1'b0; wshr_pushed_idx_i = '0;
    wshr_empty_i = 1'b1; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    mem_rsp_source_i = '0;

    //         rst wv addr    fv pr cf pi emp mr rv rs   wr fr fd pop pi mv ma      ms busy err
    // reset, then a single write with acknowledge
    vecs.push_back(V(1, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(V(0, 1, 12'h1A2, 0, 1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h1A2, 0, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 1, 0,  0, 1, 0, 1, 0, 0, 12'h1A2, 0, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h1A2, 0, 0, 0));
    // same-block conflict stalls until the cycle after the pop
    vecs.push_back(V(0, 1, 12'h1A2, 0, 1, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 12'h1A2, 0, 0, 0));
    vecs.push_back(V(0, 1, 12'h1A2, 0, 1, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h1A2, 1, 1, 0));
    vecs.push_back(V(0, 1, 12'h1A2, 0, 1, 1, 1, 1, 0, 1, 1,  0, 1, 0, 1, 1, 0, 12'h1A2, 1, 1, 0));
    vecs.push_back(V(0, 1, 12'h1A2, 0, 1, 0, 2, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 12'h1A2, 1, 0, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h1A2, 2, 1, 0));
    // WSHR full, then push and pop of idx 2 in the same cycle
    vecs.push_back(V(0, 1, 12'h055, 0, 0, 0, 2, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h1A2, 2, 1, 0));
    vecs.push_back(V(0, 1, 12'h055, 0, 1, 0, 2, 1, 0, 1, 2,  1, 1, 0, 1, 2, 0, 12'h1A2, 2, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h055, 2, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 1, 2,  0, 1, 0, 1, 2, 0, 12'h055, 2, 1, 0));
    // three writes outstanding (idx 0,1,3), then fence drain
    vecs.push_back(V(0, 1, 12'h100, 0, 1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 12'h055, 2, 0, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h100, 0, 1, 0));
    vecs.push_back(V(0, 1, 12'h101, 0, 1, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 12'h100, 0, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h101, 1, 1, 0));
    vecs.push_back(V(0, 1, 12'h102, 0, 1, 0, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 12'h101, 1, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h102, 3, 1, 0));
    vecs.push_back(V(0, 1, 12'h200, 1, 1, 0, 2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h102, 3, 1, 0));
    vecs.push_back(V(0, 1, 12'h200, 0, 1, 0, 2, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0, 12'h102, 3, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 1, 0, 12'h102, 3, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 1, 3,  0, 0, 0, 1, 3, 0, 12'h102, 3, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 12'h102, 3, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 12'h102, 3, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 12'h102, 3, 1, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h102, 3, 0, 0));
    // acknowledge with nothing outstanding: no pop, sticky error
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 1, 3,  0, 1, 0, 0, 0, 0, 12'h102, 3, 0, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h102, 3, 0, 1));
    // two writes outstanding, fence, reset mid-drain
    vecs.push_back(V(0, 1, 12'h033, 0, 1, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 12'h102, 3, 0, 1));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h033, 0, 1, 1));
    vecs.push_back(V(0, 1, 12'h044, 0, 1, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 12'h033, 0, 1, 1));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 12'h044, 1, 1, 1));
    vecs.push_back(V(0, 0, 12'h000, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h044, 1, 1, 1));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 12'h044, 1, 1, 1));
    vecs.push_back(V(1, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 12'h044, 1, 1, 1));
    vecs.push_back(V(1, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 1, 0,  0, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h000, 0, 0, 1));
    vecs.push_back(V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 12'h000, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Hand sequence: issue held under back-pressure, then reset mid-ISSUE
    idle_v = V(0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0);
    @(negedge clk);
    drive(idle_v);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_valid_i = 1'b1; wr_blockaddr_i = 12'h3FF; wshr_push_ready_i = 1'b1;
    wshr_pushed_idx_i = 2'd2;
    #1;
    chk("seq_accept", 32'(wr_ready_o), 32'd1);
    chk("seq_err_cleared", 32'(err_o), 32'd0);
    begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (!mem_req_valid_o && waited < 5) begin
        @(negedge clk);
        waited++;
      end
      chk("seq_issue_latency", 32'(waited), 32'd0);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("seq_hold_valid", 32'(mem_req_valid_o), 32'd1);
      chk("seq_hold_src", 32'(mem_req_source_o), 32'd2);
      chk("seq_hold_addr", 32'(mem_req_blockaddr_o), 32'h3FF);
      chk("seq_no_accept", 32'(wr_ready_o), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("seq_rst_valid", 32'(mem_req_valid_o), 32'd0);
    chk("seq_rst_busy", 32'(busy_o), 32'd0);
    chk("seq_rst_addr", 32'(mem_req_blockaddr_o), 32'd0);
    chk("seq_rst_wr_ready", 32'(wr_ready_o), 32'd0);
    rst = 1'b0;
    wr_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("seq_post_fence_ready", 32'(fence_ready_o), 32'd1);
    chk("seq_post_busy", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
